// File: rtl/cmp_sched.sv
// cmp_sched: round-robin sharing of one registered 16-bit equality comparator
// between the branch unit (id 0) and the set/compare ALU path (id 1).
module cmp_sched #(
   parameter int DATA_W = 16,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   input  logic              req0_op,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic              req1_op,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   output logic              req1_ready,
   output logic [DATA_W-1:0] cmp_a,
   output logic [DATA_W-1:0] cmp_b,
   output logic              cmp_eq,
   output logic              cmp_nq,
   input  logic [DATA_W-1:0] cmp_r,
   output logic              rsp_valid,
   output logic              rsp_id,
   output logic [DATA_W-1:0] rsp_result,
   input  logic              rsp_ready,
   output logic              busy,
   output logic [CNT_W-1:0]  cmp_count
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      CAPTURE,
      RESP
   } state_t;

   state_t state, state_n;
   logic   last_q;
   logic   id_q;
   logic   res_q;
   logic   gnt0, gnt1;
   logic   sel_op;
   logic   unused_r;

   // last_q holds the id granted most recently; the other side wins ties
   always_comb begin
      gnt0    = 1'b0;
      gnt1    = 1'b0;
      state_n = state;
      unique case (state)
         IDLE: begin
            if (req0_valid && (!req1_valid || last_q)) begin
               gnt0    = 1'b1;
               state_n = ISSUE;
            end else if (req1_valid) begin
               gnt1    = 1'b1;
               state_n = ISSUE;
            end
         end
         ISSUE:   state_n = CAPTURE;
         CAPTURE: state_n = RESP;
         RESP:    if (rsp_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   assign sel_op = gnt1 ? req1_op : req0_op;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         last_q    <= 1'b1;
         id_q      <= 1'b0;
         res_q     <= 1'b0;
         cmp_a     <= '0;
         cmp_b     <= '0;
         cmp_eq    <= 1'b0;
         cmp_nq    <= 1'b0;
         cmp_count <= '0;
      end else begin
         state  <= state_n;
         cmp_eq <= 1'b0;
         cmp_nq <= 1'b0;
         if (gnt0 || gnt1) begin
            cmp_a  <= gnt1 ? req1_a : req0_a;
            cmp_b  <= gnt1 ? req1_b : req0_b;
            id_q   <= gnt1;
            last_q <= gnt1;
            cmp_eq <= ~sel_op;
            cmp_nq <= sel_op;
         end
         if (state == CAPTURE) res_q <= cmp_r[0];
         if (state == RESP && rsp_ready)
            cmp_count <= cmp_count + CNT_W'(1);
      end
   end

   assign req0_ready = gnt0 & ~rst;
   assign req1_ready = gnt1 & ~rst;
   assign rsp_valid  = (state == RESP);
   assign busy       = (state != IDLE);
   assign rsp_id     = id_q;
   assign rsp_result = {{(DATA_W-1){1'b0}}, res_q};
   assign unused_r   = ^cmp_r[DATA_W-1:1];

endmodule
